scan_bist_ctrl: RTL and testbench
=================================

Name: scan_bist_ctrl

Overview:
Per-scan BIST controller that drives the scan port of a circuit-under-test (CUT) and collects its response: scan_in, scan_en and the CUT reset go out; scan_out comes back.
- Pattern source: a 16-bit LFSR shifts each pattern into the chain.
- Capture: one functional capture cycle follows each shift.
- Compaction: a 16-bit MISR absorbs the unloaded chain.
- Result: after the final flush, the signature is compared with a golden value and pass/done are reported.
It sits next to the CUT in the BIST top level and is started by a one-cycle start pulse.

Parameters:
CHAIN_LEN, 12, number of scan flops in the CUT chain (≥2)
NUM_PATTERNS, 256, scan patterns applied per run (≥1)
LFSR_SEED, 16'hACE1, LFSR value loaded in INIT (must be nonzero)
MISR_SEED, 16'h0000, MISR value loaded in INIT
GOLDEN_SIG, 16'h0000, expected final MISR signature

Ports:
clock  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle request to begin a run; honoured only in IDLE
scan_out  input  1  serial response from the CUT chain
scan_in  output  1  serial pattern bit to the CUT chain
scan_en  output  1  CUT shift enable (1 = shift, 0 = capture)
cut_reset  output  1  reset pulse to the CUT
busy  output  1  high from INIT through COMPARE inclusive
done  output  1  high in DONE, held until the next accepted start or reset
pass  output  1  valid while done=1; 1 iff signature == GOLDEN_SIG
signature  output  16  current MISR contents; final value is stable in DONE

Behaviour:
- Reset (synchronous, active-high) forces:
  - state to IDLE, LFSR to LFSR_SEED, MISR to MISR_SEED, all counters to 0;
  - all outputs to 0, with signature = MISR_SEED.
  - Reset mid-run aborts immediately, with no partial done.
- All outputs are registered or decoded from state only; there is no combinational path from scan_out or start to any output.
- LFSR step, Galois right shift: next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 0). scan_in = lfsr[0] in SHIFT, 0 otherwise.
- MISR step: next = ((misr >> 1) ^ (misr[0] ? 16'hB400 : 0)) ^ {15'b0, scan_out}.
- absorb is a one-cycle delayed copy of scan_en. The MISR steps only in cycles where absorb = 1, because the CUT updates scan_out at the edge where scan_en is high.
- FSM states:
  - IDLE: outputs low. start=1 moves to INIT; start=0 stays.
  - INIT (1 cycle): cut_reset=1, busy=1, load LFSR/MISR seeds, clear bit_cnt and pat_cnt. Goes to SHIFT.
  - SHIFT: scan_en=1, LFSR steps each cycle, bit_cnt increments. After CHAIN_LEN cycles (bit_cnt == CHAIN_LEN-1), goes to CAPTURE.
  - CAPTURE (1 cycle): scan_en=0, LFSR holds, bit_cnt clears, pat_cnt increments. If the incremented pat_cnt == NUM_PATTERNS, goes to FLUSH; otherwise back to SHIFT.
  - FLUSH: scan_en=1, scan_in=0, LFSR holds. Lasts CHAIN_LEN cycles, then goes to DRAIN.
  - DRAIN (1 cycle): scan_en=0. The MISR absorbs the last flushed bit. Goes to COMPARE.
  - COMPARE (1 cycle): busy=1; pass is registered as (MISR == GOLDEN_SIG). Goes to DONE.
  - DONE: done=1, busy=0, pass and signature held. start=1 moves to INIT and clears done/pass on that edge.
- The first pattern's unload absorbs the CUT's post-reset chain contents; this is deterministic because of cut_reset.
- Total busy cycles = 1 + NUM_PATTERNS*(CHAIN_LEN+1) + CHAIN_LEN + 2.
- Counter widths: bit_cnt uses $clog2(CHAIN_LEN+1) bits; pat_cnt uses $clog2(NUM_PATTERNS+1) bits; neither wraps during a run.
- start while busy is ignored. start asserted in the same cycle as reset is ignored.

Test Plan:
1. Cycle count and shift stream (CHAIN_LEN=4, NUM_PATTERNS=2): pulse start.
   - Required: busy high for exactly 17 cycles; done rises the cycle after busy falls; cut_reset high for exactly 1 cycle.
   - Required scan_en sequence: 1111 0 1111 0 1111 0 0.
   - Required first four scan_in bits: 1,0,0,0 (LFSR 16'hACE1 → 16'hE270 → 16'h7138 → 16'h389C).
2. Fault-free compaction (scan_out tied 0, MISR_SEED=0, GOLDEN_SIG=0): full default run → signature=16'h0000, pass=1, done=1.
3. Stuck-at-1 (scan_out tied 1, GOLDEN_SIG=0): full run → signature ≠ 0, pass=0. signature must equal a bench reference-model MISR fed with NUM_PATTERNS*CHAIN_LEN+CHAIN_LEN ones.
4. Loopback stub CUT (12-bit shift register, hold on capture, CHAIN_LEN=12, NUM_PATTERNS=4):
   - First 12 absorbed bits are 0.
   - Next 12 absorbed bits equal the first 12 scan_in bits.
   - Final signature matches the reference model.
5. Abort and reuse: assert reset during SHIFT of pattern 2 → next cycle busy=0, done=0, scan_en=0. Then pulse start → full run reproduces the same signature as an uninterrupted run.
6. start handling:
   - start pulses while busy change nothing (same cycle count, same signature).
   - start in DONE clears done/pass on that edge and begins a new run with an identical signature.

Source files
------------

// File: rtl/scan_bist_ctrl.sv
// Scan BIST controller: LFSR patterns into the CUT chain, MISR compaction of the
// unloaded response, golden-signature compare at the end of a run.
module scan_bist_ctrl #(
  parameter int unsigned CHAIN_LEN    = 12,
  parameter int unsigned NUM_PATTERNS = 256,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1,
  parameter logic [15:0] MISR_SEED    = 16'h0000,
  parameter logic [15:0] GOLDEN_SIG   = 16'h0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        scan_out,
  output logic        scan_in,
  output logic        scan_en,
  output logic        cut_reset,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] signature
);

  localparam int unsigned SIG_W = 16;
  localparam int unsigned BW    = $clog2(CHAIN_LEN + 1);
  localparam int unsigned PW    = $clog2(NUM_PATTERNS + 1);
  localparam logic [SIG_W-1:0] POLY     = 16'hB400;
  localparam logic [BW-1:0]    BIT_LAST = BW'(CHAIN_LEN - 1);
  localparam logic [PW-1:0]    PAT_LAST = PW'(NUM_PATTERNS);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_SHIFT, S_CAPTURE, S_FLUSH, S_DRAIN, S_COMPARE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [SIG_W-1:0] lfsr_q, lfsr_d;
  logic [SIG_W-1:0] misr_q, misr_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [PW-1:0]    pat_cnt_q, pat_cnt_d;
  logic [PW-1:0]    pat_inc;
  logic             absorb_q;
  logic             pass_d, scan_in_d, scan_en_d, cut_reset_d, busy_d, done_d;

  // Galois right-shift step shared by the LFSR and the MISR
  function automatic logic [SIG_W-1:0] gal_step(input logic [SIG_W-1:0] v);
    return (v >> 1) ^ (v[0] ? POLY : '0);
  endfunction

  assign signature = misr_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      misr_q    <= MISR_SEED;
      bit_cnt_q <= '0;
      pat_cnt_q <= '0;
      absorb_q  <= 1'b0;
      scan_in   <= 1'b0;
      scan_en   <= 1'b0;
      cut_reset <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      misr_q    <= misr_d;
      bit_cnt_q <= bit_cnt_d;
      pat_cnt_q <= pat_cnt_d;
      absorb_q  <= scan_en;
      scan_in   <= scan_in_d;
      scan_en   <= scan_en_d;
      cut_reset <= cut_reset_d;
      busy      <= busy_d;
      done      <= done_d;
      pass      <= pass_d;
    end
  end

  // Next state, datapath updates, and output values decoded from the next state
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    misr_d      = misr_q;
    bit_cnt_d   = bit_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    pass_d      = pass;
    pat_inc     = pat_cnt_q + PW'(1);
    scan_in_d   = 1'b0;
    scan_en_d   = 1'b0;
    cut_reset_d = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    // scan_out is valid one cycle after each shift edge
    if (absorb_q) misr_d = gal_step(misr_q) ^ {{(SIG_W-1){1'b0}}, scan_out};

    case (state_q)
      S_IDLE: if (start) state_d = S_INIT;
      S_INIT: begin
        lfsr_d    = LFSR_SEED;
        misr_d    = MISR_SEED;
        bit_cnt_d = '0;
        pat_cnt_d = '0;
        pass_d    = 1'b0;
        state_d   = S_SHIFT;
      end
      S_SHIFT: begin
        lfsr_d    = gal_step(lfsr_q);
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BIT_LAST) state_d = S_CAPTURE;
      end
      S_CAPTURE: begin
        bit_cnt_d = '0;
        pat_cnt_d = pat_inc;
        state_d   = (pat_inc == PAT_LAST) ? S_FLUSH : S_SHIFT;
      end
      S_FLUSH: begin
        bit_cnt_d = bit_cnt_q + BW'(1);
        if (bit_cnt_q == BIT_LAST) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        bit_cnt_d = '0;
        state_d   = S_COMPARE;
      end
      S_COMPARE: begin
        pass_d  = (misr_q == GOLDEN_SIG);
        state_d = S_DONE;
      end
      S_DONE: begin
        if (start) begin
          pass_d  = 1'b0;
          state_d = S_INIT;
        end
      end
      default: state_d = S_IDLE;
    endcase

    scan_en_d   = (state_d == S_SHIFT) || (state_d == S_FLUSH);
    scan_in_d   = (state_d == S_SHIFT) && lfsr_d[0];
    cut_reset_d = (state_d == S_INIT);
    busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d      = (state_d == S_DONE);
  end

endmodule

// File: tb/tb_scan_bist_ctrl.sv
// Directed bench for scan_bist_ctrl: three instances (short chain, default size with
// a driven scan_out, 12-bit loopback chain) checked against a bench-side LFSR/MISR model.
module tb_scan_bist_ctrl;

  logic        clock;
  logic        reset;
  logic [2:0]  start;
  logic [2:0]  scan_in, scan_en, cut_reset, busy, done, pass;
  logic [15:0] sig_a, sig_b, sig_c;
  logic        so_a = 1'b0, so_b = 1'b0, so_c = 1'b0;
  logic [2:0]  so_v;
  logic [3:0]  ch_a = '0;
  logic [11:0] ch_c = '0;

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  assign so_v = {so_c, so_b, so_a};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  scan_bist_ctrl #(.CHAIN_LEN(4), .NUM_PATTERNS(2)) u_a (
    .clock(clock), .reset(reset), .start(start[0]), .scan_out(so_a),
    .scan_in(scan_in[0]), .scan_en(scan_en[0]), .cut_reset(cut_reset[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .signature(sig_a));

  scan_bist_ctrl u_b (
    .clock(clock), .reset(reset), .start(start[1]), .scan_out(so_b),
    .scan_in(scan_in[1]), .scan_en(scan_en[1]), .cut_reset(cut_reset[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .signature(sig_b));

  scan_bist_ctrl #(.CHAIN_LEN(12), .NUM_PATTERNS(4)) u_c (
    .clock(clock), .reset(reset), .start(start[2]), .scan_out(so_c),
    .scan_in(scan_in[2]), .scan_en(scan_en[2]), .cut_reset(cut_reset[2]),
    .busy(busy[2]), .done(done[2]), .pass(pass[2]), .signature(sig_c));

  // Stub CUT chains: hold on capture, serial output retimed by one flop on each shift
  always @(posedge clock) begin
    if (cut_reset[0]) begin
      ch_a <= '0; so_a <= 1'b0;
    end else if (scan_en[0]) begin
      ch_a <= {ch_a[2:0], scan_in[0]}; so_a <= ch_a[3];
    end
  end

  always @(posedge clock) begin
    if (cut_reset[2]) begin
      ch_c <= '0; so_c <= 1'b0;
    end else if (scan_en[2]) begin
      ch_c <= {ch_c[10:0], scan_in[2]}; so_c <= ch_c[11];
    end
  end

  function automatic logic [15:0] gstep(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] m, input logic b);
    return gstep(m) ^ {15'b0, b};
  endfunction

  // Stub chain unload: l zeros (post-reset contents), then every pattern bit in order
  function automatic logic [15:0] ref_stub_sig(input int l, input int n);
    logic [15:0] lf, m;
    lf = 16'hACE1; m = 16'h0000;
    for (int i = 0; i < l; i++) m = mstep(m, 1'b0);
    for (int i = 0; i < n * l; i++) begin
      m  = mstep(m, lf[0]);
      lf = gstep(lf);
    end
    return m;
  endfunction

  function automatic logic [15:0] ref_ones_sig(input int cnt);
    logic [15:0] m;
    m = 16'h0000;
    for (int i = 0; i < cnt; i++) m = mstep(m, 1'b1);
    return m;
  endfunction

  function automatic logic [15:0] get_sig(input int w);
    case (w)
      0:       return sig_a;
      1:       return sig_b;
      default: return sig_c;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Pulse start at the current negedge and trace until done (bounded)
  task automatic run(input int w, input int budget, input bit poke, input string tag,
                     output int busy_cyc, output int cr_cyc, output int done_idx,
                     output logic [127:0] en_r, output logic [127:0] si_r,
                     output logic [127:0] abs_r);
    int   na;
    logic prev_en;
    busy_cyc = 0; cr_cyc = 0; done_idx = -1;
    en_r = '0; si_r = '0; abs_r = '0; na = 0; prev_en = 1'b0;
    start[w] = 1'b1;
    @(negedge clock);
    start[w] = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done[w]) begin
        done_idx = i;
        break;
      end
      if (i < 128) begin
        en_r[i] = scan_en[w];
        si_r[i] = scan_in[w];
      end
      if (prev_en && na < 128) begin
        abs_r[na] = so_v[w];
        na++;
      end
      prev_en  = scan_en[w];
      busy_cyc += int'(busy[w]);
      cr_cyc   += int'(cut_reset[w]);
      start[w] = poke && busy[w] && (i % 3 == 1);
      @(negedge clock);
    end
    start[w] = 1'b0;
    chk({tag, "_reached_done"}, 32'(done_idx >= 0), 32'd1);
  endtask

  task automatic wait_done(input int w, input int budget, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done[w]) begin
        ok = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk(tag, 32'(ok), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int             bc, cr, di;
    logic [127:0]   en_r, si_r, abs_r;
    logic [15:0]    ref_a, ref_c, ref_b1, lf;
    logic [11:0]    exp_si;

    ref_a  = ref_stub_sig(4, 2);
    ref_c  = ref_stub_sig(12, 4);
    ref_b1 = ref_ones_sig(256 * 12 + 12);
    lf = 16'hACE1;
    for (int j = 0; j < 12; j++) begin
      exp_si[j] = lf[0];
      lf = gstep(lf);
    end

    reset = 1'b1; start = '0;
    repeat (3) @(negedge clock);
    start = 3'b111;
    @(negedge clock);
    start = '0; reset = 1'b0;
    chk("reset_outputs", 32'({busy, done, pass, scan_en, scan_in, cut_reset}), 32'd0);
    chk("reset_sig_a", 32'(sig_a), 32'd0);
    chk("reset_sig_b", 32'(sig_b), 32'd0);
    @(negedge clock);
    chk("start_with_reset_ignored", 32'({busy, done, cut_reset}), 32'd0);

    // Short chain: cycle count and shift stream
    run(0, 200, 1'b0, "a_run1", bc, cr, di, en_r, si_r, abs_r);
    chk("a_busy_cycles", 32'(bc), 32'd17);
    chk("a_done_after_busy", 32'(di), 32'd17);
    chk("a_cut_reset_cycles", 32'(cr), 32'd1);
    chk("a_scan_en_seq", 32'(en_r[17:0]), 32'h7BDE);
    chk("a_first_scan_in", 32'(si_r[4:1]), 32'h1);
    chk("a_signature", 32'(sig_a), 32'(ref_a));
    chk("a_pass", 32'(pass[0]), 32'(ref_a == 16'h0000));
    chk("a_done_busy", 32'({done[0], busy[0]}), 32'b10);

    // Start pulses while busy change nothing
    run(0, 200, 1'b1, "a_poke", bc, cr, di, en_r, si_r, abs_r);
    chk("a_poke_busy_cycles", 32'(bc), 32'd17);
    chk("a_poke_signature", 32'(sig_a), 32'(ref_a));

    // Start in DONE: clears done/pass on that edge, reruns identically
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    chk("a_restart_state", 32'({done[0], pass[0], busy[0], cut_reset[0]}), 32'b0011);
    wait_done(0, 100, "a_restart_reached_done");
    chk("a_restart_signature", 32'(sig_a), 32'(ref_a));

    // Abort during SHIFT of pattern 2, then a clean run
    start[0] = 1'b1;
    @(negedge clock);
    start[0] = 1'b0;
    repeat (7) @(negedge clock);
    chk("a_mid_shift_p2", 32'({busy[0], scan_en[0]}), 32'b11);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("a_abort_outputs", 32'({busy[0], done[0], scan_en[0], pass[0]}), 32'd0);
    chk("a_abort_sig", 32'(sig_a), 32'd0);
    run(0, 200, 1'b0, "a_after_abort", bc, cr, di, en_r, si_r, abs_r);
    chk("a_after_abort_busy", 32'(bc), 32'd17);
    chk("a_after_abort_signature", 32'(sig_a), 32'(ref_a));

    // Default size, fault-free response
    so_b = 1'b0;
    run(1, 4000, 1'b0, "b_zero", bc, cr, di, en_r, si_r, abs_r);
    chk("b_busy_cycles", 32'(bc), 32'd3343);
    chk("b_zero_signature", 32'(get_sig(1)), 32'd0);
    chk("b_zero_pass_done", 32'({pass[1], done[1]}), 32'b11);

    // Stuck-at-1 response, started from DONE
    so_b = 1'b1;
    start[1] = 1'b1;
    @(negedge clock);
    start[1] = 1'b0;
    chk("b_restart_clears", 32'({done[1], pass[1], busy[1]}), 32'b001);
    wait_done(1, 4000, "b_ones_reached_done");
    chk("b_ones_signature", 32'(sig_b), 32'(ref_b1));
    chk("b_ones_nonzero", 32'(sig_b != 16'h0000), 32'd1);
    chk("b_ones_pass", 32'(pass[1]), 32'd0);

    // Loopback chain
    run(2, 200, 1'b0, "c_loop", bc, cr, di, en_r, si_r, abs_r);
    chk("c_busy_cycles", 32'(bc), 32'd67);
    chk("c_scan_in_stream", 32'(si_r[12:1]), 32'(exp_si));
    chk("c_absorb_first12_zero", 32'(abs_r[11:0]), 32'd0);
    chk("c_absorb_next12", 32'(abs_r[23:12]), 32'(exp_si));
    chk("c_signature", 32'(sig_c), 32'(ref_c));
    chk("c_pass", 32'(pass[2]), 32'(ref_c == 16'h0000));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
